// File: rtl/tron_game_pkg.sv
// -----------------------------------------------------------------------------
// tron_game_pkg
//   Shared definitions for the Tron match sequencer, the renderer and the
//   background loader: the game state encoding, the keyboard codes the
//   sequencer reacts to, and a small index-width helper.
// -----------------------------------------------------------------------------
package tron_game_pkg;

  // Encodings are visible on Game_State and decoded by the renderer, so the
  // values are fixed. 6 and 7 are unused and recover to MENU.
  typedef enum logic [2:0] {
    ST_MENU          = 3'd0,
    ST_ROUND_PAUSED  = 3'd1,
    ST_COUNTDOWN     = 3'd2,
    ST_ROUND_RUNNING = 3'd3,
    ST_ROUND_OVER    = 3'd4,
    ST_MATCH_OVER    = 3'd5
  } game_state_t;

  // USB HID usage codes
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// -----------------------------------------------------------------------------
// key_edge_detect
//   Turns the level-type USB keycode into a one-cycle press strobe. A press is
//   a nonzero code that differs from the code seen on the previous cycle, so a
//   held key fires once and switching directly between two keys fires again.
// Ports
//   Clk        in   system clock
//   Reset_n    in   asynchronous active-low reset (clears key history)
//   keycode    in   current HID keycode, 0 = no key
//   key_press  out  combinational strobe, valid in the same cycle as keycode
// -----------------------------------------------------------------------------
module key_edge_detect (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       key_press
);

  logic [7:0] key_code_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_code_q <= 8'h00;
    end else begin
      key_code_q <= keycode;
    end
  end

  assign key_press = (keycode != 8'h00) && (keycode != key_code_q);

endmodule

// File: rtl/match_state_ctrl.sv
// -----------------------------------------------------------------------------
// match_state_ctrl
//   Match sequencer for N-player Tron: menu map selection, pre-round
//   countdown, per-player elimination, score keeping and best-of match end.
// Ports
//   Clk, Reset_n      clock, asynchronous active-low reset
//   Reset_Game        sync abort to MENU (scores cleared, map kept)
//   Reset_Round       sync abort of a countdown/running round to ROUND_PAUSED
//   keycode           HID keycode, 0 = none
//   Player_Out        per-player crash indication (level or pulse)
//   Game_State        current game_state_t encoding
//   map_select        selected background
//   load_background   one-cycle pulse asking the loader to redraw
//   alive             players still riding this round
//   scores            packed, player i at [i*SCORE_W +: SCORE_W]
//   round_winner      winner of the last decided round (when !round_draw)
//   round_draw        last round ended with no survivors
//   countdown         cycles left, nonzero only in COUNTDOWN
// -----------------------------------------------------------------------------
module match_state_ctrl
  import tron_game_pkg::*;
#(
  parameter int  NUM_PLAYERS   = 2,
  parameter int  NUM_MAPS      = 4,
  parameter int  ROUNDS_TO_WIN = 3,
  parameter int  COUNTDOWN_CYC = 150,
  localparam int PLAYER_W      = idx_width(NUM_PLAYERS),
  localparam int MAP_W         = idx_width(NUM_MAPS),
  localparam int SCORE_W       = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           Reset_Game,
  input  logic                           Reset_Round,
  input  logic [7:0]                     keycode,
  input  logic [NUM_PLAYERS-1:0]         Player_Out,
  output logic [2:0]                     Game_State,
  output logic [MAP_W-1:0]               map_select,
  output logic                           load_background,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [PLAYER_W-1:0]            round_winner,
  output logic                           round_draw,
  output logic [15:0]                    countdown
);

  localparam int                     CNT_W     = $clog2(NUM_PLAYERS + 1);
  localparam logic [MAP_W-1:0]       MAP_LAST  = MAP_W'(NUM_MAPS - 1);
  localparam logic [SCORE_W-1:0]     SCORE_MAX = SCORE_W'(ROUNDS_TO_WIN);
  localparam logic [15:0]            CD_LOAD   = 16'(COUNTDOWN_CYC);
  localparam logic [NUM_PLAYERS-1:0] ALL_ALIVE = '1;

  game_state_t            state_q;
  logic [MAP_W-1:0]       map_q;
  logic                   load_bg_q;
  logic [NUM_PLAYERS-1:0] alive_q;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [PLAYER_W-1:0]    winner_q;
  logic                   draw_q;
  logic [15:0]            cd_q;

  logic                   key_press;
  logic                   key_up, key_down, key_enter;
  logic [NUM_PLAYERS-1:0] alive_d;
  logic [CNT_W-1:0]       alive_cnt_d;
  logic [PLAYER_W-1:0]    winner_d;
  logic [SCORE_W-1:0]     win_score_d;

  key_edge_detect u_key_edge (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .key_press (key_press)
  );

  assign key_up    = (keycode == KEY_UP)   || (keycode == KEY_W);
  assign key_down  = (keycode == KEY_DOWN) || (keycode == KEY_S);
  assign key_enter = (keycode == KEY_ENTER);

  // Survivors after this cycle's crashes, their count, and the lowest-index
  // survivor (scanning downwards so the lowest set bit is written last).
  // When exactly one survives, winner_d is that player; the saturating score
  // increment is prepared so the round can be decided in a single edge.
  always_comb begin
    alive_d     = alive_q & ~Player_Out;
    alive_cnt_d = '0;
    winner_d    = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (alive_d[i]) begin
        alive_cnt_d = alive_cnt_d + CNT_W'(1);
        winner_d    = PLAYER_W'(i);
      end
    end
    win_score_d = (score_q[winner_d] == SCORE_MAX) ? SCORE_MAX
                                                    : score_q[winner_d] + SCORE_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_MENU;
      map_q     <= '0;
      load_bg_q <= 1'b0;
      alive_q   <= ALL_ALIVE;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      winner_q  <= '0;
      draw_q    <= 1'b0;
      cd_q      <= '0;
    end else begin
      load_bg_q <= 1'b0;
      if (Reset_Game) begin
        state_q   <= ST_MENU;
        alive_q   <= ALL_ALIVE;
        cd_q      <= '0;
        load_bg_q <= 1'b1;
        for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      end else if (Reset_Round &&
                   (state_q == ST_COUNTDOWN || state_q == ST_ROUND_RUNNING)) begin
        state_q   <= ST_ROUND_PAUSED;
        alive_q   <= ALL_ALIVE;
        cd_q      <= '0;
        load_bg_q <= 1'b1;
      end else begin
        case (state_q)
          ST_MENU: begin
            if (key_press) begin
              if (key_up) begin
                map_q <= (map_q == MAP_LAST) ? '0 : map_q + MAP_W'(1);
              end else if (key_down) begin
                map_q <= (map_q == '0) ? MAP_LAST : map_q - MAP_W'(1);
              end else if (key_enter) begin
                state_q   <= ST_ROUND_PAUSED;
                alive_q   <= ALL_ALIVE;
                load_bg_q <= 1'b1;
                for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
              end
            end
          end
          ST_ROUND_PAUSED: begin
            if (key_press) begin
              state_q <= ST_COUNTDOWN;
              cd_q    <= CD_LOAD;
            end
          end
          ST_COUNTDOWN: begin
            // Leave on the cycle the count would hit zero; <= also catches a
            // zero load so the state can never stall here.
            if (cd_q <= 16'd1) begin
              state_q <= ST_ROUND_RUNNING;
              cd_q    <= '0;
            end else begin
              cd_q <= cd_q - 16'd1;
            end
          end
          ST_ROUND_RUNNING: begin
            alive_q <= alive_d;
            if (alive_cnt_d <= CNT_W'(1)) begin
              if (alive_cnt_d == '0) begin
                draw_q  <= 1'b1;
                state_q <= ST_ROUND_OVER;
              end else begin
                score_q[winner_d] <= win_score_d;
                winner_q          <= winner_d;
                draw_q            <= 1'b0;
                state_q           <= (win_score_d == SCORE_MAX) ? ST_MATCH_OVER
                                                                 : ST_ROUND_OVER;
              end
            end
          end
          ST_ROUND_OVER: begin
            if (key_press) begin
              state_q   <= ST_ROUND_PAUSED;
              alive_q   <= ALL_ALIVE;
              load_bg_q <= 1'b1;
            end
          end
          ST_MATCH_OVER: begin
            if (key_press) begin
              state_q   <= ST_MENU;
              load_bg_q <= 1'b1;
            end
          end
          default: state_q <= ST_MENU;
        endcase
      end
    end
  end

  assign Game_State      = state_q;
  assign map_select      = map_q;
  assign load_background = load_bg_q;
  assign alive           = alive_q;
  assign round_winner    = winner_q;
  assign round_draw      = draw_q;
  assign countdown       = cd_q;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score_pack
    assign scores[gi*SCORE_W +: SCORE_W] = score_q[gi];
  end

endmodule

// File: tb/tb_match_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_state_ctrl
//   Stimulus drives inputs on the falling edge, advances a behavioural model
//   of the match rules and queues the expected outputs; a monitor pops one
//   entry after every rising edge and compares, plus any directed spot checks
//   tagged to that cycle.
// -----------------------------------------------------------------------------
module tb_match_state_ctrl;

  localparam int NP = 2;
  localparam int NM = 4;
  localparam int RW = 3;
  localparam int CC = 5;
  localparam int SW = 2;
  localparam int ALL = (1 << NP) - 1;

  localparam int SIG_STATE = 0, SIG_MAP = 1, SIG_LB = 2, SIG_ALIVE = 3,
                 SIG_SCORES = 4, SIG_WIN = 5, SIG_DRAW = 6;

  logic          clk;
  logic          Reset_n, Reset_Game, Reset_Round;
  logic [7:0]    keycode;
  logic [NP-1:0] Player_Out;
  logic [2:0]    Game_State;
  logic [1:0]    map_select;
  logic          load_background;
  logic [NP-1:0] alive;
  logic [NP*SW-1:0] scores;
  logic [0:0]    round_winner;
  logic          round_draw;
  logic [15:0]   countdown;

  match_state_ctrl #(
    .NUM_PLAYERS(NP), .NUM_MAPS(NM), .ROUNDS_TO_WIN(RW), .COUNTDOWN_CYC(CC)
  ) dut (
    .Clk(clk), .Reset_n(Reset_n), .Reset_Game(Reset_Game), .Reset_Round(Reset_Round),
    .keycode(keycode), .Player_Out(Player_Out), .Game_State(Game_State),
    .map_select(map_select), .load_background(load_background), .alive(alive),
    .scores(scores), .round_winner(round_winner), .round_draw(round_draw),
    .countdown(countdown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int state;
    int map;
    int lb;
    int alive;
    int scores;
    int winner;
    int draw;
    int cd;
  } exp_t;

  typedef struct {
    int    idx;
    string name;
    int    sig;
    int    val;
  } spot_t;

  exp_t  exp_q[$];
  spot_t spot_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model (match rules in plain integers) --------
  localparam int M_MENU = 0, M_PAUSED = 1, M_CD = 2, M_RUN = 3, M_OVER = 4, M_MATCH = 5;

  int m_state, m_map, m_lb, m_alive, m_win, m_draw, m_cd, m_prev;
  int m_score[NP];
  int step_idx = 0;

  task automatic model_reset();
    m_state = M_MENU; m_map = 0; m_lb = 0; m_alive = ALL; m_win = 0;
    m_draw = 0; m_cd = 0; m_prev = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endtask

  task automatic model_step(input int k, input int po, input bit rg, input bit rr, input bit rn);
    bit press;
    int survivors, w;
    if (!rn) begin
      model_reset();
      return;
    end
    press  = (k != 0) && (k != m_prev);
    m_prev = k;
    m_lb   = 0;
    if (rg) begin
      m_state = M_MENU; m_alive = ALL; m_cd = 0; m_lb = 1;
      for (int i = 0; i < NP; i++) m_score[i] = 0;
    end else if (rr && (m_state == M_CD || m_state == M_RUN)) begin
      m_state = M_PAUSED; m_alive = ALL; m_cd = 0; m_lb = 1;
    end else begin
      case (m_state)
        M_MENU: if (press) begin
          if (k == 'h52 || k == 'h1A) m_map = (m_map + 1) % NM;
          else if (k == 'h51 || k == 'h16) m_map = (m_map + NM - 1) % NM;
          else if (k == 'h28) begin
            m_state = M_PAUSED; m_alive = ALL; m_lb = 1;
            for (int i = 0; i < NP; i++) m_score[i] = 0;
          end
        end
        M_PAUSED: if (press) begin m_state = M_CD; m_cd = CC; end
        M_CD: begin
          m_cd = m_cd - 1;
          if (m_cd == 0) m_state = M_RUN;
        end
        M_RUN: begin
          m_alive   = m_alive & ~po;
          survivors = $countones(m_alive[NP-1:0]);
          if (survivors == 0) begin
            m_draw = 1; m_state = M_OVER;
          end else if (survivors == 1) begin
            w = 0;
            while (((m_alive >> w) & 1) == 0) w++;
            if (m_score[w] < RW) m_score[w]++;
            m_win = w; m_draw = 0;
            m_state = (m_score[w] == RW) ? M_MATCH : M_OVER;
          end
        end
        M_OVER:  if (press) begin m_state = M_PAUSED; m_alive = ALL; m_lb = 1; end
        M_MATCH: if (press) begin m_state = M_MENU; m_lb = 1; end
        default: m_state = M_MENU;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic spot(input string nm, input int sig, input int val);
    spot_t s;
    s.idx = step_idx; s.name = nm; s.sig = sig; s.val = val;
    spot_q.push_back(s);
  endtask

  task automatic step(input logic [7:0] k, input logic [NP-1:0] po,
                      input bit rg, input bit rr, input bit rn);
    exp_t e;
    int packed_sc;
    @(negedge clk);
    keycode = k; Player_Out = po; Reset_Game = rg; Reset_Round = rr; Reset_n = rn;
    model_step(int'(k), int'(po), rg, rr, rn);
    packed_sc = 0;
    for (int i = 0; i < NP; i++) packed_sc += m_score[i] << (i * SW);
    e.idx = step_idx; e.state = m_state; e.map = m_map; e.lb = m_lb;
    e.alive = m_alive; e.scores = packed_sc; e.winner = m_win;
    e.draw = m_draw; e.cd = m_cd;
    exp_q.push_back(e);
    step_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic press(input logic [7:0] k);
    step(k, '0, 1'b0, 1'b0, 1'b1);
    step(8'h00, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // From ROUND_PAUSED: press a key, then sit out the countdown.
  task automatic start_round();
    step(8'h04, '0, 1'b0, 1'b0, 1'b1);
    idle(CC);
  endtask

  // ---------------- monitor -------------------------------------------------
  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int sig_val(input int sig);
    case (sig)
      SIG_STATE:  return int'(Game_State);
      SIG_MAP:    return int'(map_select);
      SIG_LB:     return int'(load_background);
      SIG_ALIVE:  return int'(alive);
      SIG_SCORES: return int'(scores);
      SIG_WIN:    return int'(round_winner);
      default:    return int'(round_draw);
    endcase
  endfunction

  initial begin
    exp_t  e;
    spot_t s;
    int    last_state = -1;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state",     int'(Game_State),      e.state);
        chk("map",       int'(map_select),      e.map);
        chk("load_bg",   int'(load_background), e.lb);
        chk("alive",     int'(alive),           e.alive);
        chk("scores",    int'(scores),          e.scores);
        chk("winner",    int'(round_winner),    e.winner);
        chk("draw",      int'(round_draw),      e.draw);
        chk("countdown", int'(countdown),       e.cd);
        while (spot_q.size() != 0 && spot_q[0].idx == e.idx) begin
          s = spot_q.pop_front();
          chk(s.name, sig_val(s.sig), s.val);
        end
        if (int'(Game_State) != last_state) begin
          $display("t=%0t cycle %0d state %0d map %0d alive %b scores %h winner %0d draw %0d",
                   $time, e.idx, Game_State, map_select, alive, scores, round_winner, round_draw);
          last_state = int'(Game_State);
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [7:0] keys [8];
    logic [7:0] cur_k, k;
    logic [NP-1:0] po;
    bit rg, rr, rn;

    keys[0] = 8'h00; keys[1] = 8'h00; keys[2] = 8'h52; keys[3] = 8'h1A;
    keys[4] = 8'h51; keys[5] = 8'h16; keys[6] = 8'h28; keys[7] = 8'h04;

    Reset_n = 1'b1; Reset_Game = 1'b0; Reset_Round = 1'b0;
    keycode = 8'h00; Player_Out = '0;
    model_reset();

    // Reset values
    spot("reset_state", SIG_STATE, 0);
    spot("reset_alive", SIG_ALIVE, ALL);
    step(8'h00, '0, 1'b0, 1'b0, 1'b0);
    step(8'h00, '0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Menu wrap
    spot("wrap_down_0_to_3", SIG_MAP, 3);
    press(8'h51);
    repeat (3) press(8'h52);
    spot("four_ups_back_to_3", SIG_MAP, 3);
    press(8'h52);
    spot("held_first", SIG_MAP, 0);
    step(8'h52, '0, 1'b0, 1'b0, 1'b1);
    repeat (8) step(8'h52, '0, 1'b0, 1'b0, 1'b1);
    spot("held_one_step", SIG_MAP, 0);
    step(8'h52, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Enter
    spot("enter_state", SIG_STATE, 1);
    spot("enter_lb", SIG_LB, 1);
    spot("enter_scores", SIG_SCORES, 0);
    step(8'h28, '0, 1'b0, 1'b0, 1'b1);
    spot("lb_one_cycle", SIG_LB, 0);
    idle(1);

    // Countdown with crashes ignored
    spot("cd_entered", SIG_STATE, 2);
    step(8'h04, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= CC; i++) begin
      if (i < CC) spot("cd_still_counting", SIG_STATE, 2);
      else begin
        spot("running_after_cd", SIG_STATE, 3);
        spot("cd_crash_ignored", SIG_ALIVE, 3);
      end
      step(8'h00, 2'b11, 1'b0, 1'b0, 1'b1);
    end

    // Player 0 out -> player 1 wins
    spot("p1_win_state", SIG_STATE, 4);
    spot("p1_win_idx", SIG_WIN, 1);
    spot("p1_win_score", SIG_SCORES, 4);
    step(8'h00, 2'b01, 1'b0, 1'b0, 1'b1);

    // Simultaneous crash -> draw
    press(8'h04);
    start_round();
    spot("draw_flag", SIG_DRAW, 1);
    spot("draw_scores", SIG_SCORES, 4);
    step(8'h00, 2'b11, 1'b0, 1'b0, 1'b1);

    // Player 0 takes three rounds -> match over
    for (int r = 1; r <= RW; r++) begin
      press(8'h04);
      start_round();
      spot("p0_round_state", SIG_STATE, (r == RW) ? 5 : 4);
      spot("p0_round_scores", SIG_SCORES, 4 + r);
      step(8'h00, 2'b10, 1'b0, 1'b0, 1'b1);
    end
    spot("match_to_menu", SIG_STATE, 0);
    spot("match_map_kept", SIG_MAP, 0);
    spot("match_lb", SIG_LB, 1);
    press(8'h04);

    // Reset_Round mid-round keeps 1-0
    press(8'h28);
    start_round();
    step(8'h00, 2'b10, 1'b0, 1'b0, 1'b1);
    press(8'h04);
    start_round();
    spot("rr_state", SIG_STATE, 1);
    spot("rr_scores_kept", SIG_SCORES, 1);
    spot("rr_alive", SIG_ALIVE, 3);
    spot("rr_lb", SIG_LB, 1);
    step(8'h00, '0, 1'b0, 1'b1, 1'b1);

    // Reset_Game wins over a crash in the same cycle
    start_round();
    spot("rg_state", SIG_STATE, 0);
    spot("rg_scores", SIG_SCORES, 0);
    step(8'h00, 2'b10, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Reset_n mid-round
    press(8'h28);
    start_round();
    step(8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
    press(8'h04);
    start_round();
    spot("rstn_state", SIG_STATE, 0);
    spot("rstn_scores", SIG_SCORES, 0);
    spot("rstn_lb", SIG_LB, 0);
    step(8'h00, '0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic
    cur_k = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 55) k = cur_k;
      else k = keys[$urandom_range(0, 7)];
      po = ($urandom_range(0, 9) == 0) ? NP'($urandom) : '0;
      rr = ($urandom_range(0, 79) == 0);
      rg = ($urandom_range(0, 299) == 0);
      rn = !($urandom_range(0, 699) == 0);
      step(k, po, rg, rr, rn);
      cur_k = k;
    end

    idle(1);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
